rr_burst_arbiter: RTL and testbench

Shares one downstream valid/ready stream channel between NUM_REQ upstream requesters at burst granularity. Picks a winner by round-robin, locks the grant until the winner's last beat is accepted, then advances priority past the winner. Sits between the requester ports and the shared datapath. A beat watchdog forcibly releases a grant whose burst never terminates.

---
 rtl/arb_pkg.sv | 11 +
 rtl/rr_burst_arbiter_if.sv | 30 +++
 rtl/rr_burst_arbiter_rr_pick.sv | 20 ++
 rtl/rr_burst_arbiter.sv | 88 ++++++++
 tb/tb_rr_burst_arbiter.sv | 119 +++++++++++
 5 files changed

// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding, default sizing and index helper for the burst arbiter
package arb_pkg;
  localparam int NUM_REQ_DEF   = 4;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_BEATS_DEF = 16;
  localparam int SRC_W_DEF     = $clog2(NUM_REQ_DEF);
  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
  function automatic int next_idx(input int s, input int n);
    return (s == n - 1) ? 0 : s + 1;
  endfunction
endpackage

// File: rtl/rr_burst_arbiter_if.sv
// rr_burst_arbiter_if: requester and downstream stream signals plus grant/status of the arbiter
interface rr_burst_arbiter_if
  import arb_pkg::*;
#(
  parameter  int NUM_REQ = NUM_REQ_DEF,
  parameter  int DATA_W  = DATA_W_DEF,
  localparam int SRC_W   = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic                      out_ready;
  logic [SRC_W-1:0]          out_src;
  logic [NUM_REQ-1:0]        gnt;
  logic                      busy;
  logic                      timeout_err;
  logic [SRC_W-1:0]          err_src;
  modport master (
    input  req_valid, req_data, req_last, out_ready,
    output req_ready, out_valid, out_data, out_last, out_src, gnt, busy, timeout_err, err_src
  );
  modport slave (
    output req_valid, req_data, req_last, out_ready,
    input  req_ready, out_valid, out_data, out_last, out_src, gnt, busy, timeout_err, err_src
  );
endinterface

// File: rtl/rr_burst_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr
module rr_pick #(
  parameter  int NUM_REQ = 4,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic [SRC_W-1:0]   idx_o
);
  logic [2*NUM_REQ-1:0] dbl;
  assign dbl = {req_i, req_i};
  // scan from farthest to nearest so the request closest to ptr wins
  always_comb begin
    idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (dbl[int'(ptr_i) + i]) idx_o = SRC_W'((int'(ptr_i) + i) % NUM_REQ);
    pick_o = (|req_i) ? (NUM_REQ'(1) << idx_o) : '0;
  end
endmodule

// File: rtl/rr_burst_arbiter.sv
// rr_burst_arbiter: burst-locked round-robin sharing of one stream channel with a beat watchdog
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter  int NUM_REQ   = NUM_REQ_DEF,
  parameter  int DATA_W    = DATA_W_DEF,
  parameter  int MAX_BEATS = MAX_BEATS_DEF,
  localparam int SRC_W     = $clog2(NUM_REQ),
  localparam int CNT_W     = $clog2(MAX_BEATS) + 1
) (
  input logic clk,
  input logic rst,
  rr_burst_arbiter_if.master bus
);
  localparam logic [CNT_W-1:0] CAP = CNT_W'(MAX_BEATS - 1);
  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, pick;
  logic [SRC_W-1:0]   ptr_q, ptr_d, src_q, src_d, esrc_q, esrc_d, pick_idx;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               terr_q, terr_d, busy, at_cap, accept, done, forced;
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .pick_o(pick),
    .idx_o (pick_idx)
  );
  assign busy            = (state_q == ARB_GRANT);
  assign at_cap          = (cnt_q == CAP);
  assign bus.out_valid   = busy & bus.req_valid[src_q];
  assign bus.out_data    = busy ? bus.req_data[src_q*DATA_W +: DATA_W] : '0;
  assign bus.out_last    = busy & (bus.req_last[src_q] | at_cap);
  assign bus.req_ready   = busy ? (gnt_q & {NUM_REQ{bus.out_ready}}) : '0;
  assign bus.out_src     = src_q;
  assign bus.gnt         = gnt_q;
  assign bus.busy        = busy;
  assign bus.timeout_err = terr_q;
  assign bus.err_src     = esrc_q;
  assign accept          = bus.out_valid & bus.out_ready;
  assign done            = accept & (bus.req_last[src_q] | at_cap);
  assign forced          = accept & ~bus.req_last[src_q] & at_cap;
  // arbitrate in IDLE, hold the grant until a last or watchdog beat is accepted
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    src_d   = src_q;
    esrc_d  = esrc_q;
    terr_d  = 1'b0;
    if (!busy) begin
      if (|bus.req_valid) begin
        state_d = ARB_GRANT;
        gnt_d   = pick;
        src_d   = pick_idx;
        cnt_d   = '0;
      end
    end else if (accept) begin
      cnt_d = cnt_q + 1'b1;
      if (done) begin
        state_d = ARB_IDLE;
        gnt_d   = '0;
        ptr_d   = SRC_W'(next_idx(int'(src_q), NUM_REQ));
        terr_d  = forced;
        esrc_d  = forced ? src_q : esrc_q;
      end
    end
  end
  // state registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      src_q   <= '0;
      esrc_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      esrc_q  <= esrc_d;
      terr_q  <= terr_d;
    end
  end
endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb_rr_burst_arbiter: randomized stimulus checked against a burst-level reference model
module tb_rr_burst_arbiter;
  import arb_pkg::*;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  rr_burst_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();
  rr_burst_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int n_cmp = 0;
  int n_bad = 0;
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;
  int m_terr  = 0;
  int m_esrc  = 0;
  int n_grant = 0;
  int n_tmo   = 0;
  logic [DW-1:0] d [N];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask
  task automatic check_outputs();
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_terr));
    chk("err_src", 32'(bus.err_src), 32'(m_esrc));
    if (m_owner < 0) begin
      chk("idle_busy", 32'(bus.busy), 0);
      chk("idle_gnt", 32'(bus.gnt), 0);
      chk("idle_ready", 32'(bus.req_ready), 0);
      chk("idle_valid", 32'(bus.out_valid), 0);
    end else begin
      chk("busy", 32'(bus.busy), 1);
      chk("gnt", 32'(bus.gnt), 32'(1) << m_owner);
      chk("out_src", 32'(bus.out_src), 32'(m_owner));
      chk("req_ready", 32'(bus.req_ready), bus.out_ready ? (32'(1) << m_owner) : 0);
      chk("out_valid", 32'(bus.out_valid), 32'(bus.req_valid[m_owner]));
      chk("out_data", bus.out_data, d[m_owner]);
      chk("out_last", 32'(bus.out_last), 32'(bus.req_last[m_owner] || m_beats == MB - 1));
    end
  endtask
  task automatic model_step();
    if (!rst) begin
      m_owner = -1; m_ptr = 0; m_beats = 0; m_terr = 0; m_esrc = 0;
      return;
    end
    m_terr = 0;
    if (m_owner < 0) begin
      for (int k = N - 1; k >= 0; k--)
        if (bus.req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
      m_beats = 0;
      if (m_owner >= 0) n_grant++;
    end else if (bus.req_valid[m_owner] && bus.out_ready) begin
      if (bus.req_last[m_owner] || m_beats == MB - 1) begin
        if (!bus.req_last[m_owner]) begin
          m_terr = 1; m_esrc = m_owner; n_tmo++;
        end
        m_ptr = (m_owner + 1) % N;
        m_owner = -1;
      end else m_beats++;
    end
  endtask
  task automatic drive(input int cyc);
    int p_last;
    p_last = (cyc >= 1500 && cyc < 2200) ? 0 : 25;
    rst = (cyc >= 2200 && $urandom_range(99) < 3) ? 1'b0 : 1'b1;
    bus.out_ready = ($urandom_range(99) < 70);
    for (int i = 0; i < N; i++) begin
      d[i] = $urandom();
      bus.req_data[i*DW +: DW] = d[i];
      bus.req_valid[i] = ($urandom_range(99) < 75);
      bus.req_last[i] = ($urandom_range(99) < p_last);
    end
  endtask
  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) d[i] = '0;
    repeat (2) @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
    check_outputs();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      drive(cyc);
      #1;
      if (rst) check_outputs();
      @(posedge clk);
      model_step();
    end
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = '0;
    #1;
    check_outputs();
    if (n_grant < 50) begin
      n_bad++;
      $display("FAIL coverage_grants: got %0d, expected >= 50", n_grant);
    end
    if (n_tmo < 5) begin
      n_bad++;
      $display("FAIL coverage_timeouts: got %0d, expected >= 5", n_tmo);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
